// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, machine word and the ALU arbiter state/flag types.
package cpu_types_pkg;

   localparam int WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} alu_arb_state_t;

   typedef struct packed {
      logic n;
      logic v;
      logic z;
   } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU behind the alu_if port set; unknown opcodes yield porto=0, v=0.
module alu
   import cpu_types_pkg::*;
(
   input  logic [3:0]           aluop,
   input  logic [WORD_BITS-1:0] porta,
   input  logic [WORD_BITS-1:0] portb,
   output logic [WORD_BITS-1:0] porto,
   output logic                 n,
   output logic                 v,
   output logic                 z
);

   // Signed overflow only exists for add/sub; n and z always follow the result.
   always_comb begin
      porto = '0;
      v     = 1'b0;
      case (aluop)
         ALU_SLL:  porto = porta << portb[4:0];
         ALU_SRL:  porto = porta >> portb[4:0];
         ALU_ADD: begin
            porto = porta + portb;
            v     = (porta[WORD_BITS-1] == portb[WORD_BITS-1]) &&
                    (porto[WORD_BITS-1] != porta[WORD_BITS-1]);
         end
         ALU_SUB: begin
            porto = porta - portb;
            v     = (porta[WORD_BITS-1] != portb[WORD_BITS-1]) &&
                    (porto[WORD_BITS-1] != porta[WORD_BITS-1]);
         end
         ALU_AND:  porto = porta & portb;
         ALU_OR:   porto = porta | portb;
         ALU_XOR:  porto = porta ^ portb;
         ALU_NOR:  porto = ~(porta | portb);
         ALU_SLT:  porto = WORD_BITS'($signed(porta) < $signed(portb));
         ALU_SLTU: porto = WORD_BITS'(porta < portb);
         default:  porto = '0;
      endcase
      n = porto[WORD_BITS-1];
      z = (porto == '0);
   end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant
);

   logic found;

   // Outer loop walks the search offset so the nearest requester after ptr wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == ((int'(ptr) + off) % NREQ))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ valid/ready requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module alu_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WORD_W = WORD_BITS
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*4-1:0]      req_aluop,
   input  logic [NREQ*WORD_W-1:0] req_porta,
   input  logic [NREQ*WORD_W-1:0] req_portb,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [WORD_W-1:0]      rsp_porto,
   output logic [2:0]             rsp_flags,
   output logic [3:0]             alu_aluop,
   output logic [WORD_W-1:0]      alu_porta,
   output logic [WORD_W-1:0]      alu_portb,
   input  logic [WORD_W-1:0]      alu_porto,
   input  logic                   alu_n,
   input  logic                   alu_v,
   input  logic                   alu_z,
   output logic                   busy
);

   localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   alu_arb_state_t   state;
   logic [OWN_W-1:0] owner;
   logic [NREQ-1:0]  grant;
   logic [OWN_W-1:0] grant_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic fix_found;

   always_comb begin
      grant     = '0;
      fix_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!fix_found && req_valid[i]) begin
            grant[i]  = 1'b1;
            fix_found = 1'b1;
         end
      end
   end
`else
   logic [OWN_W-1:0] rr_ptr;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (OWN_W)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );
`endif

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) grant_idx = OWN_W'(i);
      end
   end

   // The grant is offered only from a live IDLE state, so nothing is accepted while held in reset.
   assign req_ready = (nRST && (state == ARB_IDLE)) ? grant : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         rsp_valid <= '0;
         rsp_porto <= '0;
         rsp_flags <= '0;
         alu_aluop <= ALU_SLL;
         alu_porta <= '0;
         alu_portb <= '0;
         busy      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         rr_ptr    <= '0;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|grant) begin
                  alu_aluop <= req_aluop[grant_idx*4 +: 4];
                  alu_porta <= req_porta[grant_idx*WORD_W +: WORD_W];
                  alu_portb <= req_portb[grant_idx*WORD_W +: WORD_W];
                  owner     <= grant_idx;
                  busy      <= 1'b1;
                  state     <= ARB_EXEC;
               end
            end
            ARB_EXEC: begin
               rsp_porto <= alu_porto;
               rsp_flags <= alu_flags_t'{n: alu_n, v: alu_v, z: alu_z};
               rsp_valid <= NREQ'(1) << owner;
               state     <= ARB_RESP;
            end
            ARB_RESP: begin
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= ARB_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  rr_ptr    <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
`endif
               end
            end
            default: begin
               state <= ARB_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
